instr_realign: RTL and testbench
================================

Name: instr_realign

Overview:
Halfword realignment buffer between the instruction fetch unit and the decode stage. Each cycle it accepts one 32-bit word-aligned fetch word. It extracts RV64C 16-bit and 32-bit instructions at any halfword alignment, including 32-bit instructions that straddle two fetch words. It presents one instruction per cycle, with its PC and a compressed flag. The compressed expander consumes out_instr_o[15:0] when out_is_c_o=1.

Parameters:
XLEN, 64, PC width.
BUF_HW, 4, halfword buffer depth. Must be even and >= 4.
RESET_PC, 64'h0, head PC after reset. Must be word-aligned.

Ports:
clk_i  input  1  system clock.
rst_n_i  input  1  asynchronous active-low reset.
flush_i  input  1  pipeline redirect; discards all buffered halfwords.
redirect_pc_i  input  XLEN  new PC on flush. Bit 0 is ignored; bit 1 may be set.
fetch_valid_i  input  1  fetch word valid.
fetch_ready_o  output  1  buffer can accept a fetch word this cycle.
fetch_data_i  input  32  fetch word, little-endian: [15:0] is the lower address.
out_valid_o  output  1  a complete instruction is at the buffer head.
out_ready_i  input  1  decode consumes the instruction.
out_instr_o  output  32  raw instruction; [31:16]=0 when compressed.
out_is_c_o  output  1  head instruction is 16-bit (head[1:0] != 2'b11).
out_pc_o  output  XLEN  PC of the head instruction.
out_illegal_o  output  1  compressed head halfword equals 16'h0000.

Behaviour:
- State:
  - circular halfword queue hw[BUF_HW], rd_ptr, wr_ptr, count (0..BUF_HW);
  - head_pc register;
  - drop_lo flag.
- Reset (async, rst_n_i=0):
  - count=0, ptrs=0, head_pc=RESET_PC, drop_lo=0;
  - outputs: out_valid_o=0, fetch_ready_o=1, out_instr_o=0, out_is_c_o=0, out_pc_o=RESET_PC, out_illegal_o=0.
- fetch_ready_o = (count <= BUF_HW-2). It is registered-state only, with no combinational path from out_ready_i.
- Push, when fetch_valid_i && fetch_ready_o && !flush_i:
  - drop_lo=0: write [15:0] then [31:16]; count += 2.
  - drop_lo=1: write only [31:16]; count += 1; clear drop_lo.
- Head decode, combinational from queue state:
  - is_c = hw[rd][1:0] != 2'b11.
  - out_valid_o = (count>=1 && is_c) || (count>=2 && !is_c).
  - out_instr_o = is_c ? {16'b0, hw[rd]} : {hw[rd+1], hw[rd]}.
  - out_pc_o = head_pc.
- Pop, when out_valid_o && out_ready_i && !flush_i:
  - rd_ptr += (is_c ? 1 : 2), modulo BUF_HW;
  - head_pc += (is_c ? 2 : 4);
  - count decremented by the same number of halfwords.
- Simultaneous push and pop: count_next = count + pushed - popped. Both pointers advance in the same cycle.
- Flush, highest priority, synchronous:
  - count=0, rd_ptr=wr_ptr=0;
  - head_pc = {redirect_pc_i[XLEN-1:1], 1'b0};
  - drop_lo = redirect_pc_i[1];
  - any same-cycle push or pop is ignored.
  - out_valid_o=0 in the cycle after the flush.
- Latency: a word pushed in cycle N can drive out_valid_o in cycle N+1.
- Straddling: a 32-bit instruction whose upper half is not yet buffered holds out_valid_o=0. It is never partially emitted.
- Wrap-around: pointer arithmetic is modulo BUF_HW. A 32-bit head at slot BUF_HW-1 takes its upper half from slot 0.
- Back-pressure: with out_ready_i=0, the buffer fills to BUF_HW-1 or BUF_HW, fetch_ready_o drops, and no data is lost or overwritten.
- Reset mid-operation: reset returns immediately to the reset state and discards all contents.
- head_pc wraps naturally at 2^XLEN.

Decomposition:
- Shared header gets:
  - compressed detection macro (low bits 2'b11 = uncompressed);
  - halfword width constant;
  - default RESET_PC.
- Optional sub-module instr_realign_queue: halfword circular queue with push1/push2 and pop1/pop2 ports and count output.
- Head decode and PC logic stay in the top module.

Test Plan:
- Reset, then push 0x00A30413 (32-bit) from PC 0x0. Expect out_valid_o next cycle with instr=0x00A30413, is_c=0, pc=0x0. After pop, count=0.
- Push 0x45014501 (two c.li a0,0). Expect two pops: instr=0x00004501, is_c=1, pc=0x0, then pc=0x2.
- Straddle: push 0x04134501, then 0x000000A3. Expect c.li at pc=0x0; out_valid_o=0 until the second word arrives; then instr=0x00A30413, pc=0x2.
- Flush with redirect_pc_i=0x1002, then push 0x0001DEAD. Expect only the upper halfword 0x0001: is_c=1, pc=0x1002. The lower halfword is dropped.
- Back-pressure with out_ready_i=0: push compressed words until fetch_ready_o=0 (count=BUF_HW). Then release out_ready_i and check every halfword emits in order with no loss, including across pointer wrap.
- Push 0x00000000. Expect out_is_c_o=1 and out_illegal_o=1 at each halfword. Assert rst_n_i=0 with the buffer full and check all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/instr_realign_pkg.sv
// Shared constants and helpers for the halfword instruction realignment buffer.
package instr_realign_pkg;

    localparam int unsigned HW_W             = 16;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

    // RV64C: only low bits 2'b11 mark a 32-bit instruction.
    function automatic logic is_compressed(input logic [HW_W-1:0] hw);
        return (hw & 16'h0003) != 16'h0003;
    endfunction

endpackage

// File: rtl/instr_realign_queue.sv
// Circular halfword queue accepting one or two halfwords and releasing one or two per cycle.
module instr_realign_queue
    import instr_realign_pkg::*;
#(
    parameter  int unsigned BUF_HW = 4,
    localparam int unsigned PTR_W  = $clog2(BUF_HW),
    localparam int unsigned CNT_W  = $clog2(BUF_HW + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear,
    input  logic              push1,
    input  logic              push2,
    input  logic [2*HW_W-1:0] push_data,
    input  logic              pop1,
    input  logic              pop2,
    output logic [CNT_W-1:0]  count,
    output logic [HW_W-1:0]   head_lo,
    output logic [HW_W-1:0]   head_hi
);

    logic [HW_W-1:0]  hw [BUF_HW];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;

    // BUF_HW need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W+1)'(n);
        if (s >= (PTR_W+1)'(BUF_HW)) begin
            s = s - (PTR_W+1)'(BUF_HW);
        end
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        push_n = 2'd0;
        if (push2) begin
            push_n = 2'd2;
        end else if (push1) begin
            push_n = 2'd1;
        end
        pop_n = 2'd0;
        if (pop2) begin
            pop_n = 2'd2;
        end else if (pop1) begin
            pop_n = 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hw     <= '{default: '0};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push2) begin
                hw[wr_ptr]                <= push_data[HW_W-1:0];
                hw[ptr_add(wr_ptr, 2'd1)] <= push_data[2*HW_W-1:HW_W];
            end else if (push1) begin
                hw[wr_ptr] <= push_data[2*HW_W-1:HW_W];
            end
            wr_ptr <= ptr_add(wr_ptr, push_n);
            rd_ptr <= ptr_add(rd_ptr, pop_n);
            count  <= count + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

    assign head_lo = hw[rd_ptr];
    assign head_hi = hw[ptr_add(rd_ptr, 2'd1)];

endmodule

// File: rtl/instr_realign.sv
// Fetch-to-decode realignment buffer: extracts 16/32-bit RV64C instructions at any halfword offset.
module instr_realign
    import instr_realign_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     BUF_HW   = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            fetch_valid_i,
    output logic            fetch_ready_o,
    input  logic [31:0]     fetch_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     out_instr_o,
    output logic            out_is_c_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic            out_illegal_o
);

    localparam int unsigned CNT_W = $clog2(BUF_HW + 1);

    logic [CNT_W-1:0] count;
    logic [HW_W-1:0]  head_lo;
    logic [HW_W-1:0]  head_hi;
    logic [XLEN-1:0]  head_pc;
    logic             drop_lo;
    logic             has_data;
    logic             is_c;
    logic             push;
    logic             pop;

    assign fetch_ready_o = (count <= CNT_W'(BUF_HW - 2));
    assign push          = fetch_valid_i && fetch_ready_o && !flush_i;
    assign pop           = out_valid_o && out_ready_i && !flush_i;

    instr_realign_queue #(
        .BUF_HW (BUF_HW)
    ) u_queue (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clear     (flush_i),
        .push1     (push && drop_lo),
        .push2     (push && !drop_lo),
        .push_data (fetch_data_i),
        .pop1      (pop && is_c),
        .pop2      (pop && !is_c),
        .count     (count),
        .head_lo   (head_lo),
        .head_hi   (head_hi)
    );

    // Outputs are forced to zero while empty so stale slots never leak to decode.
    always_comb begin
        has_data      = (count != '0);
        is_c          = is_compressed(head_lo);
        out_valid_o   = has_data && (is_c || count >= CNT_W'(2));
        out_is_c_o    = has_data && is_c;
        out_illegal_o = has_data && is_c && (head_lo == '0);
        out_instr_o   = '0;
        if (has_data) begin
            out_instr_o = is_c ? {16'h0000, head_lo} : {head_hi, head_lo};
        end
        out_pc_o      = head_pc;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_pc <= RESET_PC;
            drop_lo <= 1'b0;
        end else if (flush_i) begin
            head_pc <= redirect_pc_i & ~XLEN'(1);
            drop_lo <= redirect_pc_i[1];
        end else begin
            if (push) begin
                drop_lo <= 1'b0;
            end
            if (pop) begin
                head_pc <= head_pc + (is_c ? XLEN'(2) : XLEN'(4));
            end
        end
    end

endmodule

// File: tb/tb_instr_realign.sv
// Directed self-checking bench for instr_realign with BUF_HW=4.
module tb_instr_realign;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [63:0] redirect_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_is_c;
    logic [63:0] out_pc;
    logic        out_illegal;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    instr_realign #(
        .XLEN     (64),
        .BUF_HW   (4),
        .RESET_PC (64'h0)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .flush_i       (flush),
        .redirect_pc_i (redirect_pc),
        .fetch_valid_i (fetch_valid),
        .fetch_ready_o (fetch_ready),
        .fetch_data_i  (fetch_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_instr_o   (out_instr),
        .out_is_c_o    (out_is_c),
        .out_pc_o      (out_pc),
        .out_illegal_o (out_illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        flush       = 1'b0;
        redirect_pc = '0;
        fetch_valid = 1'b0;
        fetch_data  = '0;
        out_ready   = 1'b0;
    endtask

    task automatic reset_dut;
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_word(input logic [31:0] w);
        fetch_valid = 1'b1;
        fetch_data  = w;
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic pop_one;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] instr, input logic c, input logic [63:0] pc);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".instr"}, out_instr, instr);
        check({tag, ".is_c"},  out_is_c,  c);
        check({tag, ".pc"},    out_pc,    pc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".valid"},   out_valid,   1'b0);
        check({tag, ".ready"},   fetch_ready, 1'b1);
        check({tag, ".instr"},   out_instr,   32'h0);
        check({tag, ".is_c"},    out_is_c,    1'b0);
        check({tag, ".pc"},      out_pc,      64'h0);
        check({tag, ".illegal"}, out_illegal, 1'b0);
    endtask

    logic [15:0] exp_hw  [6] = '{16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014, 16'h0018};
    logic        exp_rdy [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // 32-bit instruction from reset PC, one-cycle latency
        push_word(32'h00A30413);
        check_head("w32", 32'h00A30413, 1'b0, 64'h0);
        pop_one();
        check("w32.empty", out_valid, 1'b0);
        check("w32.ready", fetch_ready, 1'b1);
        check("w32.pc_next", out_pc, 64'h4);

        // two compressed instructions in one word
        reset_dut();
        push_word(32'h45014501);
        check_head("c0", 32'h00004501, 1'b1, 64'h0);
        pop_one();
        check_head("c1", 32'h00004501, 1'b1, 64'h2);
        pop_one();
        check("c.empty", out_valid, 1'b0);

        // 32-bit instruction straddling two fetch words
        reset_dut();
        push_word(32'h04134501);
        check_head("st_c", 32'h00004501, 1'b1, 64'h0);
        pop_one();
        check("st.hold0", out_valid, 1'b0);
        tick();
        check("st.hold1", out_valid, 1'b0);
        push_word(32'h000000A3);
        check_head("st_w", 32'h00A30413, 1'b0, 64'h2);

        // flush wins over a same-cycle push; lower halfword dropped afterwards
        flush       = 1'b1;
        redirect_pc = 64'h1002;
        fetch_valid = 1'b1;
        fetch_data  = 32'hFFFFFFFF;
        tick();
        idle();
        check("fl.valid", out_valid, 1'b0);
        check("fl.pc", out_pc, 64'h1002);
        check("fl.ready", fetch_ready, 1'b1);
        push_word(32'h0001DEAD);
        check_head("fl_hw", 32'h00000001, 1'b1, 64'h1002);
        check("fl.illegal", out_illegal, 1'b0);
        pop_one();
        check("fl.empty", out_valid, 1'b0);
        check("fl.pc_next", out_pc, 64'h1004);

        // redirect with bit0 set is word-aligned down, no drop
        flush       = 1'b1;
        redirect_pc = 64'h2001;
        tick();
        idle();
        push_word(32'h00084004);
        check_head("fl2", 32'h00004004, 1'b1, 64'h2000);

        // back-pressure to full, then drain across the pointer wrap
        reset_dut();
        push_word(32'h00080004);
        check("bp.ready_half", fetch_ready, 1'b1);
        push_word(32'h0010000C);
        check("bp.ready_full", fetch_ready, 1'b0);
        push_word(32'hFFFFFFFF);
        for (int i = 0; i < 6; i++) begin
            check_head($sformatf("bp%0d", i), {16'h0000, exp_hw[i]}, 1'b1, 64'(2 * i));
            check($sformatf("bp%0d.ready", i), fetch_ready, exp_rdy[i]);
            out_ready = 1'b1;
            if (i == 2) begin
                fetch_valid = 1'b1;
                fetch_data  = 32'h00180014;
            end
            tick();
            out_ready   = 1'b0;
            fetch_valid = 1'b0;
        end
        check("bp.empty", out_valid, 1'b0);
        check("bp.pc", out_pc, 64'hC);

        // 32-bit head in the last slot takes its upper half from slot 0
        push_word(32'h04134501);
        push_word(32'h000000A3);
        check_head("wr_c", 32'h00004501, 1'b1, 64'hC);
        pop_one();
        check_head("wr_w", 32'h00A30413, 1'b0, 64'hE);
        pop_one();
        check_head("wr_z", 32'h00000000, 1'b1, 64'h12);
        check("wr_z.illegal", out_illegal, 1'b1);

        // all-zero halfwords are illegal; async reset while full
        reset_dut();
        push_word(32'h00000000);
        check_head("z0", 32'h0, 1'b1, 64'h0);
        check("z0.illegal", out_illegal, 1'b1);
        pop_one();
        check_head("z1", 32'h0, 1'b1, 64'h2);
        check("z1.illegal", out_illegal, 1'b1);
        push_word(32'h00000000);
        check("z.full", fetch_ready, 1'b0);
        check("z.valid_full", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
